wait_issuer: RTL and testbench
==============================

// Module: wait_issuer
// PURPOSE
//  Initiator side of the WAIT start/din/busy protocol. Accepts a delay request
//  (8-bit count of 50 ms units) on a valid/ready handshake and drives start/din
//  to the WAIT responder. Tracks busy through its rise and fall, then reports completion,
//  elapsed clock cycles and a no-response error. Sits between the CPU control unit and WAIT.
// PARAMETERS
//  DW      8   width of the delay operand (matches WAIT din)
//  ACK_TO  4   max cycles after start for busy to rise before error (>=2)
//  CNT_W   32  width of elapsed-cycle counter (saturating)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req_valid    in   1      delay request present
//  req_din      in   DW     requested delay, units of WAIT period
//  req_ready    out  1      request accepted when valid&ready
//  wt_start     out  1      start pulse to WAIT, one cycle
//  wt_din       out  DW     operand to WAIT, stable while wt_start=1
//  wt_busy      in   1      WAIT busy
//  done         out  1      one-cycle pulse, request finished
//  err          out  1      with done: busy never rose within ACK_TO
//  elapsed      out  CNT_W  cycles from start to busy fall, held until next accept
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; req_ready, wt_start, done, err=0;
//   wt_din=0; elapsed=0; timeout counter 0.
//  States: IDLE, ISSUE, ARM, RUN, DONE.
//  IDLE: req_ready = !wt_busy (never accept while responder still busy, e.g. after
//   reset mid-delay). On accept: latch req_din; clear elapsed and err.
//   din!=0 -> ISSUE. din==0 -> DONE directly, no start issued, elapsed=0, err=0.
//  ISSUE: wt_start=1, wt_din=latched value for exactly this cycle; elapsed<=1;
//   timeout counter<=0; -> ARM.
//  ARM: elapsed increments each cycle. wt_busy=1 -> RUN. Else if counter
//   reaches ACK_TO-1 -> DONE with err=1. Responder busy rises one cycle after start.
//  RUN: elapsed increments while wt_busy=1; wt_busy=0 -> DONE (elapsed not
//   incremented on the falling cycle).
//  DONE: done=1 for one cycle, err valid same cycle; -> IDLE.
//  req_ready=0 in every state but IDLE; requests in other states wait (no drop).
//  elapsed saturates at all-ones, never wraps.
//  Back-to-back: DONE->IDLE->accept gives min 1 idle cycle between starts;
//   responder's extra trailing busy cycle is absorbed by IDLE's !wt_busy gate.
//  wt_busy glitch to 0 in RUN is treated as completion (no filtering).
//  Reset mid-operation: FSM returns to IDLE immediately; no done pulse; request lost.
// STRUCTURE
//  Shared package hrm_pkg: state encoding enum (IDLE/ISSUE/ARM/RUN/DONE),
//   WAIT_DW=8 constant shared with the WAIT responder.
//  Sub-module sat_counter (CNT_W, clear, inc, saturate) used for elapsed.
//  Timeout counter is $clog2(ACK_TO) bits, inline.
// TESTING (bench pairs wait_issuer with WAIT in simulation build, MAXC=5)
//  Reset: rst_n low mid-RUN -> all outputs 0 next edge; req_ready stays 0 until
//   wt_busy falls, then 1.
//  req_din=1 -> one wt_start pulse with wt_din=1; done pulse, err=0, elapsed=6.
//  req_din=0 -> no wt_start; done 2 cycles after accept, err=0, elapsed=0.
//  Responder disconnected (wt_busy tied 0), req_din=3 -> done with err=1
//   ACK_TO+1 cycles after start cycle (elapsed=ACK_TO).
//  req_din=3, req_valid held high with next req_din=2 -> second accept only after
//   done and wt_busy=0; exactly two wt_start pulses; elapsed=16 then 11.
//  CNT_W=4, req_din=4 -> elapsed saturates at 15, done still issued, err=0.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared definitions for the WAIT initiator/responder pair.
package hrm_pkg;

  // Operand width shared with the WAIT responder din port.
  localparam int unsigned WAIT_DW = 8;

  // Initiator sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } wi_state_e;

endpackage : hrm_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and inc together yield 1.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: optional clear, then increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end
    if (inc_i && (cnt_d != '1)) begin
      cnt_d = cnt_d + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/wait_issuer.sv
// Initiator side of the WAIT start/din/busy protocol: issues a delay, follows
// busy through rise and fall, reports completion, elapsed cycles and no-response.
module wait_issuer
  import hrm_pkg::*;
#(
  parameter int unsigned DW     = WAIT_DW,
  parameter int unsigned ACK_TO = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  input  logic [DW-1:0]    req_din_i,
  output logic             req_ready_o,
  output logic             wt_start_o,
  output logic [DW-1:0]    wt_din_o,
  input  logic             wt_busy_i,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] elapsed_o
);

  localparam int unsigned TW = $clog2(ACK_TO);

  wi_state_e         state_q, state_d;
  logic [DW-1:0]     din_q, din_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [TW-1:0]     tmo_inc;
  logic              err_flag_q, err_flag_d;
  logic              ready_q, ready_d;
  logic              start_q, start_d;
  logic [DW-1:0]     wt_din_q, wt_din_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              el_clr_c;
  logic              el_inc_c;

  // Next-state, elapsed-counter control and registered-output next values.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    tmo_d      = tmo_q;
    err_flag_d = err_flag_q;
    el_clr_c   = 1'b0;
    el_inc_c   = 1'b0;
    tmo_inc    = tmo_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          din_d      = req_din_i;
          el_clr_c   = 1'b1;
          err_flag_d = 1'b0;
          state_d    = (req_din_i != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        // Start cycle counts as the first elapsed cycle.
        el_clr_c = 1'b1;
        el_inc_c = 1'b1;
        tmo_d    = '0;
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        el_inc_c = 1'b1;
        if (wt_busy_i) begin
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(ACK_TO - 1)) begin
            err_flag_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // Any low sample of busy ends the delay; the falling cycle is not counted.
        if (wt_busy_i) begin
          el_inc_c = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Never offer acceptance while the responder is still busy.
    ready_d  = (state_d == ST_IDLE) && !wt_busy_i;
    start_d  = (state_d == ST_ISSUE);
    wt_din_d = start_d ? din_d : '0;
    done_d   = (state_q == ST_DONE);
    err_d    = (state_q == ST_DONE) && err_flag_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      din_q      <= '0;
      tmo_q      <= '0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      wt_din_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      tmo_q      <= tmo_d;
      err_flag_q <= err_flag_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      wt_din_q   <= wt_din_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Elapsed-cycle counter, saturating at all-ones.
  sat_counter #(
    .W (CNT_W)
  ) u_elapsed (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (el_clr_c),
    .inc_i (el_inc_c),
    .cnt_o (elapsed_o)
  );

  assign req_ready_o = ready_q;
  assign wt_start_o  = start_q;
  assign wt_din_o    = wt_din_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule : wait_issuer

// File: tb/tb_wait_issuer.sv
// Bench for wait_issuer paired with a simple WAIT responder model (MAXC=5).
module tb_wait_issuer;

  localparam int unsigned MAXC   = 5;
  localparam int unsigned ACK_TO = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SAT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Main instance signals
  logic             valid_m = 1'b0;
  logic [7:0]       din_m   = 8'd0;
  logic             ready_m, start_m, busy_m, done_m, err_m;
  logic [7:0]       wdin_m;
  logic [CNT_W-1:0] el_m;
  bit               en_m    = 1'b1;
  int               rem_m   = 0;

  // Narrow-counter instance signals
  logic             valid_s = 1'b0;
  logic [7:0]       din_s   = 8'd0;
  logic             ready_s, start_s, busy_s, done_s, err_s;
  logic [7:0]       wdin_s;
  logic [SAT_W-1:0] el_s;
  int               rem_s   = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  din;
    bit          en;
    logic [31:0] el;
    bit          er;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  wait_issuer #(.DW(8), .ACK_TO(ACK_TO), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (valid_m),
    .req_din_i   (din_m),
    .req_ready_o (ready_m),
    .wt_start_o  (start_m),
    .wt_din_o    (wdin_m),
    .wt_busy_i   (busy_m),
    .done_o      (done_m),
    .err_o       (err_m),
    .elapsed_o   (el_m)
  );

  wait_issuer #(.DW(8), .ACK_TO(ACK_TO), .CNT_W(SAT_W)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (valid_s),
    .req_din_i   (din_s),
    .req_ready_o (ready_s),
    .wt_start_o  (start_s),
    .wt_din_o    (wdin_s),
    .wt_busy_i   (busy_s),
    .done_o      (done_s),
    .err_o       (err_s),
    .elapsed_o   (el_s)
  );

  // Responder models: busy for din*MAXC cycles starting one cycle after start;
  // they ignore the initiator's reset, like a separate block would.
  always @(posedge clk) begin
    if (start_m && en_m) rem_m <= int'(wdin_m) * int'(MAXC);
    else if (rem_m != 0) rem_m <= rem_m - 1;
    if (start_s) rem_s <= int'(wdin_s) * int'(MAXC);
    else if (rem_s != 0) rem_s <= rem_s - 1;
  end
  assign busy_m = en_m && (rem_m != 0);
  assign busy_s = (rem_s != 0);

  // Reference: outcome of one request from the protocol rules.
  function automatic vec_t model(input logic [7:0] din, input bit en);
    vec_t v;
    v.din = din;
    v.en  = en;
    if (din == 8'd0) begin
      v.el = 0; v.er = 1'b0; v.lat = 2;
    end else if (!en) begin
      v.el = ACK_TO; v.er = 1'b1; v.lat = int'(ACK_TO) + 2;
    end else begin
      v.el = int'(din) * int'(MAXC) + 1; v.er = 1'b0; v.lat = int'(din) * int'(MAXC) + 4;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One request on the main instance; called and returns at a falling edge.
  task automatic do_txn(input vec_t v, input string tag);
    int          w   = 0;
    int          lat = 0;
    int          ns  = 0;
    logic [7:0]  sd  = 8'd0;
    bit          got = 1'b0;
    logic [31:0] el  = 0;
    logic        er  = 1'b0;
    en_m = v.en;
    while (!ready_m && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!ready_m) begin
      chk({tag, " ready_wait"}, 32'(ready_m), 32'd1);
      return;
    end
    valid_m = 1'b1;
    din_m   = v.din;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(negedge clk);
      if (k == 1) valid_m = 1'b0;
      if (start_m) begin ns++; sd = wdin_m; end
      if (done_m) begin got = 1'b1; lat = k; el = el_m; er = err_m; end
    end
    if (!got) begin
      chk({tag, " done_wait"}, 32'(got), 32'd1);
      return;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " elapsed"}, el, v.el);
    chk({tag, " err"}, 32'(er), 32'(v.er));
    chk({tag, " starts"}, 32'(ns), (v.din != 8'd0) ? 32'd1 : 32'd0);
    if (v.din != 8'd0) chk({tag, " wt_din"}, 32'(sd), 32'(v.din));
    @(negedge clk);
    chk({tag, " done_width"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int   m;
    bit   bad;
    bit   got;
    int   acc, dn, ns, lat;
    logic [31:0] els[2];
    logic [7:0]  sds[2];
    bit          acc2_ok;

    // {din, responder connected, elapsed, err, accept->done cycles}
    vecs[0] = '{8'd1, 1'b1, 32'd6,  1'b0, 9};
    vecs[1] = '{8'd0, 1'b1, 32'd0,  1'b0, 2};
    vecs[2] = '{8'd3, 1'b0, 32'd4,  1'b1, 6};
    vecs[3] = '{8'd2, 1'b1, 32'd11, 1'b0, 14};
    vecs[4] = '{8'd3, 1'b1, 32'd16, 1'b0, 19};

    // Reset state
    #1;
    chk("rst ready", 32'(ready_m), 32'd0);
    chk("rst start", 32'(start_m), 32'd0);
    chk("rst wt_din", 32'(wdin_m), 32'd0);
    chk("rst done", 32'(done_m), 32'd0);
    chk("rst err", 32'(err_m), 32'd0);
    chk("rst elapsed", el_m, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 5; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Randomized requests against the reference model
    for (int i = 0; i < 12; i++) begin
      rv = model(8'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0));
      do_txn(rv, $sformatf("rnd%0d", i));
    end

    // Held request: second accept only after done and with busy low
    en_m = 1'b1;
    m = 0;
    while (!ready_m && m < 300) begin @(negedge clk); m++; end
    valid_m = 1'b1;
    din_m   = 8'd3;
    acc = 0; dn = 0; ns = 0; acc2_ok = 1'b0;
    for (int k = 0; k < 200 && dn < 2; k++) begin
      if (k > 0) @(negedge clk);
      if (start_m) begin
        if (ns < 2) sds[ns] = wdin_m;
        ns++;
      end
      if (done_m) begin
        if (dn < 2) els[dn] = el_m;
        dn++;
      end
      if (acc == 1 && din_m == 8'd3 && !ready_m) din_m = 8'd2;
      if (acc == 2) valid_m = 1'b0;
      if (valid_m && ready_m) begin
        acc++;
        if (acc == 2) acc2_ok = (dn >= 1) && !busy_m;
      end
    end
    valid_m = 1'b0;
    chk("b2b dones", 32'(dn), 32'd2);
    chk("b2b accepts", 32'(acc), 32'd2);
    chk("b2b second accept gated", 32'(acc2_ok), 32'd1);
    chk("b2b starts", 32'(ns), 32'd2);
    if (dn == 2) begin
      chk("b2b elapsed0", els[0], 32'd16);
      chk("b2b elapsed1", els[1], 32'd11);
    end
    if (ns == 2) begin
      chk("b2b din0", 32'(sds[0]), 32'd3);
      chk("b2b din1", 32'(sds[1]), 32'd2);
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of a running delay
    m = 0;
    while (!ready_m && m < 300) begin @(negedge clk); m++; end
    valid_m = 1'b1;
    din_m   = 8'd2;
    @(negedge clk);
    valid_m = 1'b0;
    m = 0;
    while (!busy_m && m < 20) begin @(negedge clk); m++; end
    chk("midrst busy rose", 32'(busy_m), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst start", 32'(start_m), 32'd0);
    chk("midrst elapsed", el_m, 32'd0);
    @(negedge clk);
    chk("midrst ready", 32'(ready_m), 32'd0);
    chk("midrst done", 32'(done_m), 32'd0);
    chk("midrst err", 32'(err_m), 32'd0);
    chk("midrst wt_din", 32'(wdin_m), 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    m = 0;
    while (busy_m && m < 100) begin
      if (ready_m || done_m) bad = 1'b1;
      @(negedge clk);
      m++;
    end
    chk("midrst still busy after release", 32'(m > 0), 32'd1);
    chk("midrst no ready/done while busy", 32'(bad), 32'd0);
    @(negedge clk);
    chk("midrst ready after fall", 32'(ready_m), 32'd1);

    // Narrow counter saturates
    m = 0;
    while (!ready_s && m < 300) begin @(negedge clk); m++; end
    valid_s = 1'b1;
    din_s   = 8'd4;
    got = 1'b0; ns = 0; lat = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (k == 1) valid_s = 1'b0;
      if (start_s) ns++;
      if (done_s) begin
        got = 1'b1;
        lat = k;
        chk("sat elapsed", 32'(el_s), 32'd15);
        chk("sat err", 32'(err_s), 32'd0);
      end
    end
    chk("sat done seen", 32'(got), 32'd1);
    chk("sat latency", 32'(lat), 32'd24);
    chk("sat starts", 32'(ns), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wait_issuer
